// File: rtl/csr_bridge_pkg.sv
// Shared types and constants for the multi-channel CSR bridge.
package csr_bridge_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_SEL_LSB = 16;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_TIMEOUT = 1024;
endpackage

// File: rtl/csr_bridge_if.sv
// Requester-side register bus of the CSR bridge.
interface csr_bridge_if;
  logic        registerSelect;
  logic        registerRead;
  logic [31:0] registerAddress;
  logic [31:0] registerWriteData;
  logic        registerAck;
  logic        registerError;
  logic [31:0] registerReadData;

  modport master (
    output registerSelect, registerRead, registerAddress, registerWriteData,
    input  registerAck, registerError, registerReadData
  );

  modport slave (
    input  registerSelect, registerRead, registerAddress, registerWriteData,
    output registerAck, registerError, registerReadData
  );
endinterface

// File: rtl/csr_bridge_timer.sv
// ISSUE-phase cycle counter; expired_o flags the TIMEOUT-th cycle of a strobe.
module csr_bridge_timer
  import csr_bridge_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clockCore,
  input  logic resetCore,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  // cnt_q lags the 1-based cycle count by one
  assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/csr_bridge_mc.sv
// Single-requester bridge fanning register accesses out to NUM_CH CSR targets.
module csr_bridge_mc
  import csr_bridge_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int SEL_LSB = DEF_SEL_LSB,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clockCore,
  input  logic                   resetCore,
  csr_bridge_if.slave            bus,
  output logic [NUM_CH-1:0]      csrRead,
  output logic [NUM_CH-1:0]      csrWrite,
  output logic [31:0]            csrAddress,
  output logic [31:0]            csrWriteData,
  input  logic [32*NUM_CH-1:0]   csrReadData,
  input  logic [NUM_CH-1:0]      csrWaitRequest,
  output logic [15:0]            errorCount
);
  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ISSUE = ST_ISSUE;
  localparam logic [1:0] RESP  = ST_RESP;

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NSEL = 1 << CH_W;
  // Decodable index values that map onto a real channel
  localparam logic [NSEL-1:0] CH_OK = NSEL'((64'd1 << NUM_CH) - 64'd1);

  logic [1:0]             state_q, state_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic                   rd_q, rd_d;
  logic [NUM_CH-1:0]      rstb_q, rstb_d, wstb_q, wstb_d;
  logic [31:0]            addr_q, addr_d, wdat_q, wdat_d, rdat_q, rdat_d;
  logic                   ack_q, ack_d, err_q, err_d;
  logic [15:0]            errcnt_q, errcnt_d;

  logic [CH_W-1:0]        req_ch;
  logic [NSEL-1:0]        req_oh;
  logic [NSEL-1:0][31:0]  rdata_pad;
  logic [NSEL-1:0]        wait_pad;
  logic                   expired, err_evt, unused_addr;

  assign req_ch      = bus.registerAddress[SEL_LSB +: CH_W];
  assign req_oh      = NSEL'(1) << req_ch;
  assign rdata_pad   = (NSEL*32)'(csrReadData);
  assign wait_pad    = NSEL'(csrWaitRequest);
  assign unused_addr = ^bus.registerAddress;

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    rd_d     = rd_q;
    rstb_d   = rstb_q;
    wstb_d   = wstb_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    rdat_d   = rdat_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    err_evt  = 1'b0;
    errcnt_d = errcnt_q;
    case (state_q)
      IDLE: if (bus.registerSelect) begin
        ch_d   = req_ch;
        rd_d   = bus.registerRead;
        addr_d = 32'(bus.registerAddress[ADDR_W-1:0]);
        if (!bus.registerRead) wdat_d = bus.registerWriteData;
        if (CH_OK[req_ch]) begin
          state_d = ISSUE;
          if (bus.registerRead) rstb_d = req_oh[NUM_CH-1:0];
          else                  wstb_d = req_oh[NUM_CH-1:0];
        end else begin
          state_d = RESP;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          err_evt = 1'b1;
        end
      end
      ISSUE: if (!wait_pad[ch_q] || expired) begin
        state_d = RESP;
        rstb_d  = '0;
        wstb_d  = '0;
        ack_d   = 1'b1;
        if (!wait_pad[ch_q]) begin
          if (rd_q) rdat_d = rdata_pad[ch_q];
        end else begin
          err_d   = 1'b1;
          err_evt = 1'b1;
          if (rd_q) rdat_d = TIMEOUT_RDATA;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (err_evt && errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
  end

  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      rd_q     <= 1'b0;
      rstb_q   <= '0;
      wstb_q   <= '0;
      addr_q   <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      rd_q     <= rd_d;
      rstb_q   <= rstb_d;
      wstb_q   <= wstb_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  csr_bridge_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clockCore (clockCore),
    .resetCore (resetCore),
    .clear_i   (state_q != ISSUE),
    .enable_i  (state_q == ISSUE),
    .expired_o (expired)
  );

  assign csrRead              = rstb_q;
  assign csrWrite             = wstb_q;
  assign csrAddress           = addr_q;
  assign csrWriteData         = wdat_q;
  assign errorCount           = errcnt_q;
  assign bus.registerAck      = ack_q;
  assign bus.registerError    = err_q;
  assign bus.registerReadData = rdat_q;
endmodule

// File: tb/tb_csr_bridge_mc.sv
// Directed bench: 4-channel and 3-channel bridges, both with TIMEOUT=16.
module tb_csr_bridge_mc;
  logic clockCore, resetCore;

  csr_bridge_if bus4();
  csr_bridge_if bus3();

  logic [3:0]   csrRead4, csrWrite4, csrWaitRequest4;
  logic [31:0]  csrAddress4, csrWriteData4;
  logic [127:0] csrReadData4;
  logic [15:0]  errorCount4;
  logic [2:0]   csrRead3, csrWrite3, csrWaitRequest3;
  logic [31:0]  csrAddress3, csrWriteData3;
  logic [95:0]  csrReadData3;
  logic [15:0]  errorCount3;

  int nchk = 0;
  int nerr = 0;
  int cnt;

  csr_bridge_mc #(.NUM_CH(4), .TIMEOUT(16)) u4 (
    .clockCore(clockCore), .resetCore(resetCore), .bus(bus4),
    .csrRead(csrRead4), .csrWrite(csrWrite4), .csrAddress(csrAddress4),
    .csrWriteData(csrWriteData4), .csrReadData(csrReadData4),
    .csrWaitRequest(csrWaitRequest4), .errorCount(errorCount4)
  );

  csr_bridge_mc #(.NUM_CH(3), .TIMEOUT(16)) u3 (
    .clockCore(clockCore), .resetCore(resetCore), .bus(bus3),
    .csrRead(csrRead3), .csrWrite(csrWrite3), .csrAddress(csrAddress3),
    .csrWriteData(csrWriteData3), .csrReadData(csrReadData3),
    .csrWaitRequest(csrWaitRequest3), .errorCount(errorCount3)
  );

  initial clockCore = 1'b0;
  always #5 clockCore = ~clockCore;

  task automatic tick();
    @(posedge clockCore);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    resetCore = 1'b0;
    bus4.registerSelect = 0; bus4.registerRead = 0;
    bus4.registerAddress = '0; bus4.registerWriteData = '0;
    bus3.registerSelect = 0; bus3.registerRead = 0;
    bus3.registerAddress = '0; bus3.registerWriteData = '0;
    csrWaitRequest4 = '0; csrWaitRequest3 = '0;
    csrReadData4 = {32'h3333_0003, 32'h2222_0002, 32'hCAFE_0001, 32'h1111_0000};
    csrReadData3 = {32'h3C3C_0002, 32'h2B2B_0001, 32'h1A1A_0000};
    tick(); tick();
    chk("rst_strobes", {csrRead4, csrWrite4}, 8'h00);
    chk("rst_ack", {bus4.registerAck, bus4.registerError}, 2'b00);
    chk("rst_rdata", bus4.registerReadData, 32'h0);
    chk("rst_errcnt", errorCount4, 16'h0);
    resetCore = 1'b1;
    tick();

    // write to ch2, waitrequest released in the 4th strobe cycle
    csrWaitRequest4 = 4'b1111;
    bus4.registerSelect = 1; bus4.registerRead = 0;
    bus4.registerAddress = 32'h0002_0010; bus4.registerWriteData = 32'h1234_5678;
    tick();
    chk("wr_addr", csrAddress4, 32'h0000_0010);
    chk("wr_data", csrWriteData4, 32'h1234_5678);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("wr_stb%0d", i), {csrRead4, csrWrite4}, 8'b0000_0100);
      if (i == 4) csrWaitRequest4 = 4'b1011;
      tick();
    end
    chk("wr_stb_drop", {csrRead4, csrWrite4}, 8'h00);
    chk("wr_ack", {bus4.registerAck, bus4.registerError}, 2'b10);
    chk("wr_rdata_hold", bus4.registerReadData, 32'h0);
    bus4.registerSelect = 0;
    tick();
    chk("wr_ack_1cyc", {bus4.registerAck, bus4.registerError}, 2'b00);

    // zero-wait read from ch1
    csrWaitRequest4 = 4'b0000;
    bus4.registerSelect = 1; bus4.registerRead = 1; bus4.registerAddress = 32'h0001_0004;
    tick();
    chk("rd_stb", {csrRead4, csrWrite4}, 8'b0010_0000);
    chk("rd_addr", csrAddress4, 32'h0000_0004);
    chk("rd_wdata_keep", csrWriteData4, 32'h1234_5678);
    tick();
    chk("rd_stb_drop", {csrRead4, csrWrite4}, 8'h00);
    chk("rd_ack", {bus4.registerAck, bus4.registerError}, 2'b10);
    chk("rd_data", bus4.registerReadData, 32'hCAFE_0001);
    bus4.registerSelect = 0;
    tick();
    chk("rd_ack_1cyc", bus4.registerAck, 1'b0);

    // ch3 read that never sees waitrequest low
    csrWaitRequest4 = 4'b1111;
    bus4.registerSelect = 1; bus4.registerRead = 1; bus4.registerAddress = 32'h0003_0008;
    tick();
    cnt = 0;
    while (csrRead4 == 4'b1000 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("to_cycles", cnt, 16);
    chk("to_ack", {bus4.registerAck, bus4.registerError}, 2'b11);
    chk("to_rdata", bus4.registerReadData, 32'hDEAD_BEEF);
    chk("to_errcnt", errorCount4, 16'd1);
    bus4.registerSelect = 0;
    tick();
    chk("to_err_1cyc", {bus4.registerAck, bus4.registerError}, 2'b00);

    // out-of-range index on the 3-channel bridge
    bus3.registerSelect = 1; bus3.registerRead = 1; bus3.registerAddress = 32'h0003_0000;
    tick();
    chk("inv_stb", {csrRead3, csrWrite3}, 6'b0);
    chk("inv_ack", {bus3.registerAck, bus3.registerError}, 2'b11);
    chk("inv_errcnt", errorCount3, 16'd1);
    bus3.registerSelect = 0;
    tick();
    chk("inv_ack_1cyc", {bus3.registerAck, bus3.registerError}, 2'b00);
    bus3.registerSelect = 1; bus3.registerAddress = 32'h0002_0000;
    tick();
    chk("ch2_stb3", {csrRead3, csrWrite3}, 6'b100_000);
    tick();
    chk("ch2_rdata3", bus3.registerReadData, 32'h3C3C_0002);
    chk("ch2_ack3", {bus3.registerAck, bus3.registerError}, 2'b10);
    bus3.registerSelect = 0;
    tick();

    // reset asserted while a ch0 write is stalled
    bus4.registerSelect = 1; bus4.registerRead = 0;
    bus4.registerAddress = 32'h0000_0020; bus4.registerWriteData = 32'hA5A5_5A5A;
    tick();
    chk("mid_stb", {csrRead4, csrWrite4}, 8'b0000_0001);
    #2 resetCore = 1'b0;
    #1;
    chk("arst_stb", {csrRead4, csrWrite4}, 8'h00);
    chk("arst_addr", csrAddress4, 32'h0);
    chk("arst_wdata", csrWriteData4, 32'h0);
    chk("arst_resp", {bus4.registerAck, bus4.registerError}, 2'b00);
    chk("arst_rdata", bus4.registerReadData, 32'h0);
    chk("arst_errcnt", errorCount4, 16'h0);
    tick();
    chk("arst_noack", bus4.registerAck, 1'b0);
    bus4.registerSelect = 0;
    csrWaitRequest4 = 4'b0000;
    csrReadData4[63:32] = 32'h1111_2222;
    resetCore = 1'b1;
    tick();
    bus4.registerSelect = 1; bus4.registerRead = 1; bus4.registerAddress = 32'h0001_0000;
    tick();
    chk("post_stb", {csrRead4, csrWrite4}, 8'b0010_0000);
    tick();
    chk("post_ack", {bus4.registerAck, bus4.registerError}, 2'b10);
    chk("post_rdata", bus4.registerReadData, 32'h1111_2222);
    bus4.registerSelect = 0;
    tick();

    // error counter saturation with back-to-back invalid accesses
    force u3.errcnt_q = 16'hFFFD;
    #1 release u3.errcnt_q;
    chk("sat_preload", errorCount3, 16'hFFFD);
    bus3.registerSelect = 1; bus3.registerRead = 0; bus3.registerAddress = 32'h0003_0000;
    tick(); chk("sat_1", errorCount3, 16'hFFFE);
    tick(); chk("sat_idle", bus3.registerAck, 1'b0);
    tick(); chk("sat_2", errorCount3, 16'hFFFF);
    tick();
    tick(); chk("sat_hold", errorCount3, 16'hFFFF);
    chk("sat_ack", {bus3.registerAck, bus3.registerError}, 2'b11);
    bus3.registerSelect = 0;
    tick(); tick();
    chk("sat_final", errorCount3, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
